// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    // Responder control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_DEPTH_DEF   = 64;
    localparam int DMEM_LATENCY_DEF = 2;
    localparam int DMEM_STRB_W      = 4;
    localparam int DMEM_CNT_W       = 4;

    // Merge the strobed byte lanes of new_word over old_word.
    function automatic logic [31:0] dmem_strobe_merge(
        input logic [31:0]            old_word,
        input logic [31:0]            new_word,
        input logic [DMEM_STRB_W-1:0] strb
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < DMEM_STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-strobed word storage: combinational read, posedge write.
// Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH_DEF,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      idx,
    input  logic [31:0]            wdata,
    input  logic [DMEM_STRB_W-1:0] wstrb,
    output logic [31:0]            rdata
);

    logic [31:0] mem_q [DEPTH];

    assign rdata = mem_q[idx];

    // Byte-lane write of the addressed word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[idx] <= dmem_strobe_merge(mem_q[idx], wdata, wstrb);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency request/response front end for a word-addressed data memory.
// A request is captured in IDLE, held for LATENCY-1 counter cycles in WAIT,
// performed on the last WAIT edge, and presented in RESP until accepted.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH_DEF,
    parameter int LATENCY = DMEM_LATENCY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    input  logic [DMEM_STRB_W-1:0] req_wstrb,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err
);

    localparam int                    ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0]           DEPTH_W  = 30'(DEPTH);
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);
    localparam logic [DMEM_CNT_W-1:0] CNT_ZERO = DMEM_CNT_W'(0);
    localparam logic [DMEM_CNT_W-1:0] CNT_ONE  = DMEM_CNT_W'(1);

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [DMEM_STRB_W-1:0]  wstrb_q, wstrb_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic                    acc_err_s;
    logic                    mem_we_s;
    logic                    mem_wr_en_s;
    logic [ADDR_W-1:0]       mem_idx_s;
    logic [31:0]             mem_rdata_s;

    // Misaligned or beyond-the-array accesses never touch storage.
    assign acc_err_s = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);
    assign mem_idx_s = addr_q[ADDR_W+1:2];
    // A write committing on a reset edge is dropped so an aborted request leaves memory intact.
    assign mem_wr_en_s = mem_we_s & ~reset;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .wr_en (mem_wr_en_s),
        .idx   (mem_idx_s),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .rdata (mem_rdata_s)
    );

    // Next-state, capture and response computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    cnt_d       = CNT_LOAD;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err_s;
                    mem_we_s    = we_q & ~acc_err_s;
                    if (acc_err_s || we_q) begin
                        rsp_rdata_d = 32'h0000_0000;
                    end else begin
                        rsp_rdata_d = mem_rdata_s;
                    end
                end
            end
            RESP: begin
                // Returning to IDLE here means the next accept is at least one edge later.
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = CNT_ZERO;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'h0000_0000;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset overrides any handshake on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            wstrb_q     <= {DMEM_STRB_W{1'b0}};
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner
// sequences, randomized traffic against a word-array model, latency sweep.
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // sweep instances share one request stream
    logic        sw_req_valid = 1'b0;
    logic        sw_rsp_ready = 1'b1;
    logic [1:0]  sw_rdy;
    logic [1:0]  sw_vld;
    logic [1:0]  sw_err;
    logic [31:0] sw_rdata0, sw_rdata1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(sw_req_valid), .req_ready(sw_rdy[0]), .req_we(1'b1),
        .req_addr(32'h0000_0010), .req_wdata(32'h0BAD_CAFE), .req_wstrb(4'hF),
        .rsp_valid(sw_vld[0]), .rsp_ready(sw_rsp_ready),
        .rsp_rdata(sw_rdata0), .rsp_err(sw_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(15)) u_l15 (
        .clk(clk), .reset(reset),
        .req_valid(sw_req_valid), .req_ready(sw_rdy[1]), .req_we(1'b1),
        .req_addr(32'h0000_0010), .req_wdata(32'h0BAD_CAFE), .req_wstrb(4'hF),
        .rsp_valid(sw_vld[1]), .rsp_ready(sw_rsp_ready),
        .rsp_rdata(sw_rdata1), .rsp_err(sw_err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference behaviour: word-indexed array, byte lanes, error rules.
    function automatic void ref_access(input logic we, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [3:0] strb,
                                       output logic [31:0] rd, output logic er);
        int w;
        w  = int'(addr >> 2);
        er = (addr % 4 != 0) || ((addr >> 2) >= DEPTH);
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[w];
            end
        end
    endfunction

    // One complete transaction on the LATENCY=2 instance with full protocol checks.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int hold,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rd;
        logic        exp_er;
        int n, lat, bad;
        n = 0;
        while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        ref_access(we, addr, wdata, strb, exp_rd, exp_er);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        // junk request kept asserted while busy: must be ignored
        req_we = 1'b1; req_addr = 32'h0; req_wdata = $urandom; req_wstrb = 4'hF;
        lat = 0; bad = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (req_ready !== 1'b0) bad++;
            @(posedge clk); #1; lat++;
        end
        chk("latency", 32'(lat), 32'(LAT));
        chk("rdata", rsp_rdata, exp_rd);
        chk("err", {31'd0, rsp_err}, {31'd0, exp_er});
        rdata = rsp_rdata; err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== exp_er || req_ready !== 1'b0)
                bad++;
        end
        chk("busy_stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_valid_clr", {31'd0, rsp_valid}, 32'd0);
        chk("rdata_clr", rsp_rdata, 32'd0);
        chk("err_clr", {31'd0, rsp_err}, 32'd0);
        chk("idle_after_hs", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          hold;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        int          last_acc [2];
        int          nacc [2];
        bit          waiting [2];
        logic        rdy_prev [2];
        int          lat_exp [2];

        vecs[0]  = '{1'b1, 32'd88,        32'hBEEE_F009, 4'hF,    0, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'd88,        32'h0,         4'h0,    0, 32'hBEEE_F009, 1'b0};
        vecs[2]  = '{1'b1, 32'd0,         32'h1122_3344, 4'hF,    0, 32'h0,         1'b0};
        vecs[3]  = '{1'b1, 32'd0,         32'hAABB_CCDD, 4'b0101, 0, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'd0,         32'h0,         4'h3,    5, 32'h11BB_33DD, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0102, 32'h0,         4'hF,    0, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'd256,       32'hDEAD_BEEF, 4'hF,    0, 32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'd252,       32'h1357_9BDF, 4'hF,    0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'd252,       32'hCAFE_F00D, 4'h0,    0, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'd252,       32'h0,         4'h0,    2, 32'h1357_9BDF, 1'b0};
        vecs[10] = '{1'b0, 32'd256,       32'h0,         4'hF,    0, 32'h0,         1'b1};
        vecs[11] = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 4'hF,    0, 32'h0,         1'b1};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);

        // give every word a known value
        for (int i = 0; i < DEPTH; i++) do_txn(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].hold, rd, er);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
        end

        // reset while counter is still running
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd4; req_wdata = 32'h1234_5678; req_wstrb = 4'hF;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort1_ready", {31'd0, req_ready}, 32'd1);
        chk("abort1_valid", {31'd0, rsp_valid}, 32'd0);
        // reset on the very edge the write would commit
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n = 0;
        repeat (20) begin
            if (rsp_valid !== 1'b0) n++;
            @(posedge clk); #1;
        end
        chk("abort_no_rsp", 32'(n), 32'd0);
        do_txn(1'b0, 32'd4, 32'h0, 4'hF, 0, rd, er);

        // reset wins over an offered request in IDLE
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd8; req_wdata = 32'hFEED_0000; req_wstrb = 4'hF;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        chk("rst_prio_ready", {31'd0, req_ready}, 32'd1);

        // reset in RESP drops the response
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd12; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("resp_reached", {31'd0, rsp_valid}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("resp_drop_valid", {31'd0, rsp_valid}, 32'd0);
        chk("resp_drop_rdata", rsp_rdata, 32'd0);
        chk("resp_drop_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;

        // full readback: error writes and aborts changed nothing
        for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 32'(i * 4), 32'h0, 4'h0, 0, rd, er);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(0, DEPTH - 1) * 4) | 32'($urandom_range(1, 3));
                1:       a = 32'($urandom_range(DEPTH, 4000) * 4);
                2:       a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
                default: a = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er);
        end

        // latency sweep: LATENCY 1 and 15 with requests offered continuously
        lat_exp[0] = 1; lat_exp[1] = 15;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        sw_req_valid = 1'b1;
        for (int d = 0; d < 2; d++) begin
            last_acc[d] = -1; nacc[d] = 0; waiting[d] = 1'b0; rdy_prev[d] = sw_rdy[d];
        end
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                if (rdy_prev[d] === 1'b1) begin
                    if (last_acc[d] >= 0)
                        chk($sformatf("spacing_L%0d", lat_exp[d]), 32'(cyc - last_acc[d]), 32'(lat_exp[d] + 2));
                    if (waiting[d])
                        chk($sformatf("no_rsp_L%0d", lat_exp[d]), 32'd1, 32'd0);
                    last_acc[d] = cyc; nacc[d]++; waiting[d] = 1'b1;
                end
                if (waiting[d] && sw_vld[d] === 1'b1) begin
                    chk($sformatf("latency_L%0d", lat_exp[d]), 32'(cyc - last_acc[d]), 32'(lat_exp[d]));
                    waiting[d] = 1'b0;
                end
                rdy_prev[d] = sw_rdy[d];
            end
        end
        sw_req_valid = 1'b0;
        chk("sweep_acc_L1", {31'd0, nacc[0] >= 3}, 32'd1);
        chk("sweep_acc_L15", {31'd0, nacc[1] >= 3}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
